uart_autobaud: RTL and testbench

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_autobaud_if.sv | 33 +++
 rtl/uart_autobaud.sv | 190 +++++++++++++++++++
 tb/tb_uart_autobaud.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_autobaud_if.sv
// ---------------------------------------------------------------------------
// uart_autobaud_if
// Groups the auto-baud detector's line input, control levels and results.
//   rxd            : raw asynchronous UART line, idle high
//   enable         : level, run detection
//   relock         : single-cycle pulse, discard lock and re-measure
//   prescale       : measured clocks-per-bit / 8, as consumed by uart_rx
//   prescale_valid : single-cycle pulse when prescale is updated
//   locked         : level, prescale holds a valid measurement
//   busy           : level, a sync character is being measured
//   error          : single-cycle pulse, measurement rejected
// master = driver of line/controls, slave = the detector itself.
// ---------------------------------------------------------------------------
interface uart_autobaud_if;
    logic        rxd;
    logic        enable;
    logic        relock;
    logic [15:0] prescale;
    logic        prescale_valid;
    logic        locked;
    logic        busy;
    logic        error;

    modport master (
        output rxd, enable, relock,
        input  prescale, prescale_valid, locked, busy, error
    );

    modport slave (
        input  rxd, enable, relock,
        output prescale, prescale_valid, locked, busy, error
    );
endinterface

// File: rtl/uart_autobaud.sv
// ---------------------------------------------------------------------------
// uart_autobaud
// Measures the bit period of a 0x55 sync character on an asynchronous UART
// line and publishes it as a uart_rx prescale value (clocks per bit / 8).
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : uart_autobaud_if.slave (rxd, enable, relock in;
//           prescale, prescale_valid, locked, busy, error out)
// Parameters:
//   IDLE_CLKS    : consecutive idle-high cycles needed before arming
//   MIN_SEG_CLKS : shortest legal edge-to-edge segment (shorter = glitch)
//   MAX_SEG_CLKS : longest legal segment (reaching it without edge = timeout)
// ---------------------------------------------------------------------------
module uart_autobaud #(
    parameter int IDLE_CLKS    = 1024,
    parameter int MIN_SEG_CLKS = 8,
    parameter int MAX_SEG_CLKS = 524280
) (
    input logic            clk,
    input logic            rst_n,
    uart_autobaud_if.slave bus
);

    localparam int IW = $clog2(IDLE_CLKS + 1);
    localparam int SW = $clog2(MAX_SEG_CLKS + 1);
    // Eight maximal segments plus rounding must never wrap.
    localparam int TW = (SW + 4 > 24) ? SW + 4 : 24;

    localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_CLKS);
    localparam logic [SW-1:0] MIN_LEN  = SW'(MIN_SEG_CLKS);
    localparam logic [SW-1:0] MAX_LEN  = SW'(MAX_SEG_CLKS);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_START, MEASURE, LOCKED} state_t;

    state_t        state;
    logic          rxd_meta, rxd_s, rxd_prev;
    logic [IW-1:0] idle_cnt;
    logic [SW-1:0] seg_cnt;
    logic [2:0]    edge_cnt;
    logic [TW-1:0] total;
    logic [SW-1:0] seg_min, seg_max;
    logic [15:0]   prescale_r;
    logic          valid_r, locked_r, busy_r, error_r;

    logic          rx_edge, rx_fall;
    logic [SW-1:0] seg_len, seg_min_n, seg_max_n;
    logic [TW-1:0] total_n, rounded;
    logic          spread_ok;
    logic [15:0]   prescale_n;

    assign rx_edge = rxd_s ^ rxd_prev;
    assign rx_fall = rxd_prev & ~rxd_s;

    // seg_cnt restarts at 0 on the cycle of each edge, so the segment
    // ending on the current cycle is one longer than the count.
    assign seg_len   = seg_cnt + SW'(1);
    assign seg_min_n = (edge_cnt == 3'd0 || seg_len < seg_min) ? seg_len : seg_min;
    assign seg_max_n = (edge_cnt == 3'd0 || seg_len > seg_max) ? seg_len : seg_max;
    assign total_n   = total + TW'(seg_len);
    assign spread_ok = TW'(seg_max_n - seg_min_n) <= (total_n >> 5);
    // Eight bits measured, prescale is per-bit / 8, hence total / 64 rounded.
    assign rounded    = (total_n + TW'(32)) >> 6;
    assign prescale_n = (rounded > TW'(16'hFFFF)) ? 16'hFFFF : rounded[15:0];

    assign bus.prescale       = prescale_r;
    assign bus.prescale_valid = valid_r;
    assign bus.locked         = locked_r;
    assign bus.busy           = busy_r;
    assign bus.error          = error_r;

    // Synchronizer, detection FSM and all measurement registers. enable low
    // overrides everything; relock restarts the measurement except in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rxd_meta   <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_prev   <= 1'b1;
            idle_cnt   <= '0;
            seg_cnt    <= '0;
            edge_cnt   <= '0;
            total      <= '0;
            seg_min    <= '0;
            seg_max    <= '0;
            prescale_r <= '0;
            valid_r    <= 1'b0;
            locked_r   <= 1'b0;
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rxd_meta <= bus.rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
            busy_r   <= 1'b0;

            if (!bus.enable) begin
                state    <= IDLE;
                idle_cnt <= '0;
                seg_cnt  <= '0;
                edge_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        idle_cnt <= '0;
                        state    <= locked_r ? LOCKED : ARM;
                    end
                    ARM: begin
                        if (bus.relock || !rxd_s) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt + IW'(1) == IDLE_LIM) begin
                            state <= WAIT_START;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    WAIT_START: begin
                        if (bus.relock) begin
                            state    <= ARM;
                            idle_cnt <= '0;
                        end else if (rx_fall) begin
                            state    <= MEASURE;
                            busy_r   <= 1'b1;
                            seg_cnt  <= '0;
                            edge_cnt <= '0;
                            total    <= '0;
                            seg_min  <= '0;
                            seg_max  <= '0;
                        end
                    end
                    MEASURE: begin
                        busy_r <= 1'b1;
                        if (bus.relock) begin
                            state    <= ARM;
                            busy_r   <= 1'b0;
                            idle_cnt <= '0;
                            seg_cnt  <= '0;
                            edge_cnt <= '0;
                        end else if (rx_edge) begin
                            seg_cnt <= '0;
                            if (seg_len < MIN_LEN) begin
                                error_r  <= 1'b1;
                                state    <= ARM;
                                busy_r   <= 1'b0;
                                idle_cnt <= '0;
                            end else begin
                                seg_min  <= seg_min_n;
                                seg_max  <= seg_max_n;
                                total    <= total_n;
                                edge_cnt <= edge_cnt + 3'd1;
                                // Eighth segment closes the fifth falling edge.
                                if (edge_cnt == 3'd7) begin
                                    busy_r <= 1'b0;
                                    if (spread_ok) begin
                                        prescale_r <= prescale_n;
                                        valid_r    <= 1'b1;
                                        locked_r   <= 1'b1;
                                        state      <= LOCKED;
                                    end else begin
                                        error_r  <= 1'b1;
                                        state    <= ARM;
                                        idle_cnt <= '0;
                                    end
                                end
                            end
                        end else if (seg_len >= MAX_LEN) begin
                            error_r  <= 1'b1;
                            state    <= ARM;
                            busy_r   <= 1'b0;
                            idle_cnt <= '0;
                        end else begin
                            seg_cnt <= seg_cnt + SW'(1);
                        end
                    end
                    LOCKED: begin
                        if (bus.relock) begin
                            locked_r <= 1'b0;
                            state    <= ARM;
                            idle_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// ---------------------------------------------------------------------------
// tb_uart_autobaud
// Self-checking bench for uart_autobaud. Sync characters are described as a
// list of level durations; a reference model derives acceptance and the
// expected prescale from those durations with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_uart_autobaud;

    localparam int IDLE_T = 64;
    localparam int MAX_T  = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_autobaud_if ifc();

    uart_autobaud #(
        .IDLE_CLKS   (IDLE_T),
        .MIN_SEG_CLKS(8),
        .MAX_SEG_CLKS(MAX_T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int checks        = 0;
    int fails         = 0;
    int cyc           = 0;
    int err_cnt       = 0;
    int val_cnt       = 0;
    int busy_cnt      = 0;
    int busy_rise_cyc = 0;
    int err_cyc       = 0;
    bit busy_q        = 1'b0;
    bit both_seen     = 1'b0;
    int dur[10];
    int exp_presc;

    // Pulse and level bookkeeping, sampled on the falling edge away from
    // the active clock edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ifc.error === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (ifc.prescale_valid === 1'b1) val_cnt = val_cnt + 1;
        if (ifc.busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (ifc.busy === 1'b1 && !busy_q) busy_rise_cyc = cyc;
        busy_q = (ifc.busy === 1'b1);
        if (ifc.error === 1'b1 && ifc.prescale_valid === 1'b1) both_seen = 1'b1;
    end

    // Advance n rising edges and land just after the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_line(input int n);
        ifc.rxd = 1'b1;
        cycles(n);
    endtask

    task automatic pulse_relock();
        ifc.relock = 1'b1;
        cycles(1);
        ifc.relock = 1'b0;
    endtask

    task automatic set_period(input int p);
        for (int i = 0; i < 10; i++) dur[i] = p;
    endtask

    // 0x55 framed: start(0), bits 1,0,1,0,1,0,1,0, stop(1): alternating
    // levels starting low, level i lasting dur[i] cycles.
    task automatic send_frame();
        for (int i = 0; i < 10; i++) begin
            ifc.rxd = (i % 2) != 0;
            cycles(dur[i]);
        end
        ifc.rxd = 1'b1;
        cycles(8);
    endtask

    // Reference: the eight segments between edge 0 and edge 8 are dur[0..7].
    task automatic model_frame(output bit accept, output int presc);
        int total, mn, mx, q;
        total = 0;
        mn    = dur[0];
        mx    = dur[0];
        for (int i = 0; i < 8; i++) begin
            total = total + dur[i];
            if (dur[i] < mn) mn = dur[i];
            if (dur[i] > mx) mx = dur[i];
        end
        accept = (mx - mn) <= (total / 32);
        q      = (total + 32) / 64;
        presc  = (q > 65535) ? 65535 : q;
    endtask

    // Reset state: every output low while rst_n is held.
    task automatic test_reset();
        rst_n      = 1'b0;
        ifc.rxd    = 1'b1;
        ifc.enable = 1'b0;
        ifc.relock = 1'b0;
        cycles(4);
        checks++; if (ifc.prescale !== 16'd0) begin fails++; $display("[TB] FAIL reset_prescale: got %0d expected 0", ifc.prescale); end
        checks++; if (ifc.prescale_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", ifc.prescale_valid); end
        checks++; if (ifc.locked !== 1'b0) begin fails++; $display("[TB] FAIL reset_locked: got %b expected 0", ifc.locked); end
        checks++; if (ifc.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", ifc.busy); end
        checks++; if (ifc.error !== 1'b0) begin fails++; $display("[TB] FAIL reset_error: got %b expected 0", ifc.error); end
        rst_n = 1'b1;
        cycles(2);
    endtask

    // First lock at 64 clocks per bit; busy must span exactly the total.
    task automatic test_lock_64();
        int e0, v0, b0;
        e0 = err_cnt; v0 = val_cnt; b0 = busy_cnt;
        ifc.enable = 1'b1;
        idle_line(100);
        set_period(64);
        send_frame();
        checks++; if (ifc.prescale !== 16'd8) begin fails++; $display("[TB] FAIL lock64_prescale: got %0d expected 8", ifc.prescale); end
        checks++; if (val_cnt - v0 !== 1) begin fails++; $display("[TB] FAIL lock64_valid_pulses: got %0d expected 1", val_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin fails++; $display("[TB] FAIL lock64_errors: got %0d expected 0", err_cnt - e0); end
        checks++; if (ifc.locked !== 1'b1) begin fails++; $display("[TB] FAIL lock64_locked: got %b expected 1", ifc.locked); end
        checks++; if (ifc.busy !== 1'b0) begin fails++; $display("[TB] FAIL lock64_busy_after: got %b expected 0", ifc.busy); end
        checks++; if (busy_cnt - b0 !== 512) begin fails++; $display("[TB] FAIL lock64_busy_cycles: got %0d expected 512", busy_cnt - b0); end
    endtask

    // Relock from LOCKED, then re-measure at 128 clocks per bit.
    task automatic test_relock_128();
        int v0;
        v0 = val_cnt;
        pulse_relock();
        checks++; if (ifc.locked !== 1'b0) begin fails++; $display("[TB] FAIL relock_clears_locked: got %b expected 0", ifc.locked); end
        idle_line(100);
        set_period(128);
        send_frame();
        checks++; if (ifc.prescale !== 16'd16) begin fails++; $display("[TB] FAIL relock128_prescale: got %0d expected 16", ifc.prescale); end
        checks++; if (ifc.locked !== 1'b1) begin fails++; $display("[TB] FAIL relock128_locked: got %b expected 1", ifc.locked); end
        checks++; if (val_cnt - v0 !== 1) begin fails++; $display("[TB] FAIL relock128_valid_pulses: got %0d expected 1", val_cnt - v0); end
    endtask

    // A 4-cycle low glitch is rejected, then a clean frame locks.
    task automatic test_glitch();
        int e0;
        pulse_relock();
        idle_line(100);
        e0 = err_cnt;
        ifc.rxd = 1'b0;
        cycles(4);
        ifc.rxd = 1'b1;
        cycles(10);
        checks++; if (err_cnt - e0 !== 1) begin fails++; $display("[TB] FAIL glitch_error_pulse: got %0d expected 1", err_cnt - e0); end
        checks++; if (ifc.busy !== 1'b0) begin fails++; $display("[TB] FAIL glitch_busy: got %b expected 0", ifc.busy); end
        idle_line(100);
        set_period(64);
        send_frame();
        checks++; if (ifc.prescale !== 16'd8) begin fails++; $display("[TB] FAIL glitch_final_prescale: got %0d expected 8", ifc.prescale); end
        checks++; if (err_cnt - e0 !== 1) begin fails++; $display("[TB] FAIL glitch_total_errors: got %0d expected 1", err_cnt - e0); end
        checks++; if (ifc.locked !== 1'b1) begin fails++; $display("[TB] FAIL glitch_locked: got %b expected 1", ifc.locked); end
    endtask

    // One segment stretched to 96: spread 32 exceeds limit 17.
    task automatic test_stretch();
        int e0, v0;
        pulse_relock();
        idle_line(100);
        e0 = err_cnt; v0 = val_cnt;
        set_period(64);
        dur[3] = 96;
        send_frame();
        checks++; if (err_cnt - e0 !== 1) begin fails++; $display("[TB] FAIL stretch_error_pulse: got %0d expected 1", err_cnt - e0); end
        checks++; if (val_cnt - v0 !== 0) begin fails++; $display("[TB] FAIL stretch_valid_pulses: got %0d expected 0", val_cnt - v0); end
        checks++; if (ifc.locked !== 1'b0) begin fails++; $display("[TB] FAIL stretch_locked: got %b expected 0", ifc.locked); end
        checks++; if (ifc.prescale !== 16'd8) begin fails++; $display("[TB] FAIL stretch_prescale_held: got %0d expected 8", ifc.prescale); end
    endtask

    // Start bit held low: timeout exactly MAX_T cycles after edge 0, then
    // the detector is re-armed and locks at 100 clocks per bit.
    task automatic test_timeout();
        int e0, b0;
        idle_line(100);
        e0 = err_cnt;
        ifc.rxd = 1'b0;
        cycles(MAX_T + 100);
        checks++; if (err_cnt - e0 !== 1) begin fails++; $display("[TB] FAIL timeout_error_pulse: got %0d expected 1", err_cnt - e0); end
        checks++; if (err_cyc - busy_rise_cyc !== MAX_T) begin fails++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", err_cyc - busy_rise_cyc, MAX_T); end
        checks++; if (ifc.busy !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy: got %b expected 0", ifc.busy); end
        idle_line(100);
        b0 = busy_cnt;
        set_period(100);
        send_frame();
        checks++; if (ifc.prescale !== 16'd13) begin fails++; $display("[TB] FAIL lock100_prescale: got %0d expected 13", ifc.prescale); end
        checks++; if (ifc.locked !== 1'b1) begin fails++; $display("[TB] FAIL lock100_locked: got %b expected 1", ifc.locked); end
        checks++; if (busy_cnt - b0 !== 800) begin fails++; $display("[TB] FAIL lock100_total: got %0d expected 800", busy_cnt - b0); end
    endtask

    // enable low holds results; relock ignored in IDLE; enable beats relock.
    task automatic test_enable();
        int e0, v0;
        e0 = err_cnt; v0 = val_cnt;
        ifc.enable = 1'b0;
        cycles(3);
        checks++; if (ifc.locked !== 1'b1) begin fails++; $display("[TB] FAIL disable_locked_held: got %b expected 1", ifc.locked); end
        checks++; if (ifc.prescale !== 16'd13) begin fails++; $display("[TB] FAIL disable_prescale_held: got %0d expected 13", ifc.prescale); end
        ifc.enable = 1'b1;
        ifc.relock = 1'b1;
        cycles(1);
        ifc.relock = 1'b0;
        cycles(3);
        checks++; if (ifc.locked !== 1'b1) begin fails++; $display("[TB] FAIL idle_relock_ignored: got %b expected 1", ifc.locked); end
        checks++; if (val_cnt - v0 !== 0) begin fails++; $display("[TB] FAIL reenable_valid_pulses: got %0d expected 0", val_cnt - v0); end
        pulse_relock();
        idle_line(100);
        ifc.rxd = 1'b0;
        cycles(50);
        ifc.rxd = 1'b1;
        cycles(20);
        checks++; if (ifc.busy !== 1'b1) begin fails++; $display("[TB] FAIL midmeasure_busy: got %b expected 1", ifc.busy); end
        ifc.enable = 1'b0;
        ifc.relock = 1'b1;
        cycles(1);
        ifc.relock = 1'b0;
        cycles(3);
        checks++; if (ifc.busy !== 1'b0) begin fails++; $display("[TB] FAIL drop_busy: got %b expected 0", ifc.busy); end
        checks++; if (err_cnt - e0 !== 0) begin fails++; $display("[TB] FAIL drop_no_error: got %0d expected 0", err_cnt - e0); end
        checks++; if (ifc.prescale !== 16'd13) begin fails++; $display("[TB] FAIL drop_prescale_held: got %0d expected 13", ifc.prescale); end
        ifc.enable = 1'b1;
        cycles(2);
    endtask

    // Random bit periods with per-segment jitter and occasional stretches.
    task automatic test_random();
        int e0, v0, p, j, k;
        bit acc;
        int presc;
        exp_presc = 13;
        for (int it = 0; it < 6; it++) begin
            pulse_relock();
            idle_line(100);
            p = $urandom_range(120, 16);
            set_period(p);
            for (int i = 0; i < 8; i++) begin
                j = $urandom_range(p / 8, 0);
                dur[i] = p + j - p / 16;
            end
            if ($urandom_range(2, 0) == 0) begin
                k = $urandom_range(7, 0);
                dur[k] = dur[k] + p / 2;
            end
            model_frame(acc, presc);
            if (acc) exp_presc = presc;
            e0 = err_cnt; v0 = val_cnt;
            send_frame();
            checks++; if (val_cnt - v0 !== int'(acc)) begin fails++; $display("[TB] FAIL rand%0d_valid: got %0d expected %0d (p=%0d)", it, val_cnt - v0, acc, p); end
            checks++; if (err_cnt - e0 !== int'(!acc)) begin fails++; $display("[TB] FAIL rand%0d_error: got %0d expected %0d (p=%0d)", it, err_cnt - e0, !acc, p); end
            checks++; if (int'(ifc.prescale) !== exp_presc) begin fails++; $display("[TB] FAIL rand%0d_prescale: got %0d expected %0d (p=%0d)", it, ifc.prescale, exp_presc, p); end
            checks++; if (ifc.locked !== acc) begin fails++; $display("[TB] FAIL rand%0d_locked: got %b expected %b (p=%0d)", it, ifc.locked, acc, p); end
        end
    endtask

    // Reset in the middle of a measurement clears everything silently.
    task automatic test_reset_mid_measure();
        int e0, v0;
        pulse_relock();
        idle_line(100);
        ifc.rxd = 1'b0;
        cycles(40);
        ifc.rxd = 1'b1;
        cycles(40);
        checks++; if (ifc.busy !== 1'b1) begin fails++; $display("[TB] FAIL premid_busy: got %b expected 1", ifc.busy); end
        e0 = err_cnt; v0 = val_cnt;
        rst_n = 1'b0;
        cycles(2);
        checks++; if (ifc.prescale !== 16'd0) begin fails++; $display("[TB] FAIL midrst_prescale: got %0d expected 0", ifc.prescale); end
        checks++; if (ifc.locked !== 1'b0) begin fails++; $display("[TB] FAIL midrst_locked: got %b expected 0", ifc.locked); end
        checks++; if (ifc.busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", ifc.busy); end
        checks++; if (ifc.error !== 1'b0 || ifc.prescale_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pulses: got error=%b valid=%b expected 0 0", ifc.error, ifc.prescale_valid); end
        checks++; if (err_cnt - e0 !== 0 || val_cnt - v0 !== 0) begin fails++; $display("[TB] FAIL midrst_no_pulse: got %0d errors %0d valids expected 0 0", err_cnt - e0, val_cnt - v0); end
        rst_n = 1'b1;
        cycles(4);
    endtask

    // error and prescale_valid must never coincide across the whole run.
    task automatic test_no_overlap();
        checks++; if (both_seen !== 1'b0) begin fails++; $display("[TB] FAIL error_valid_overlap: got %b expected 0", both_seen); end
    endtask

    // Scenario sequence; later tests rely on the state earlier ones leave.
    initial begin
        ifc.rxd    = 1'b1;
        ifc.enable = 1'b0;
        ifc.relock = 1'b0;
        $display("[TB] uart_autobaud bench start");
        test_reset();
        test_lock_64();
        test_relock_128();
        test_glitch();
        test_stretch();
        test_timeout();
        test_enable();
        test_random();
        test_reset_mid_measure();
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
